// File: rtl/hyperbolic_cordic_unit_if.sv
// Handshake bundle for hyperbolic_cordic_unit: input operand side and result side.
// The master drives operands and accepts results; the slave is the CORDIC engine.
interface hyperbolic_cordic_unit_if #(
    parameter int NUM_W = 16
);
    logic [NUM_W-1:0] in_data;
    logic             in_mode;
    logic             in_valid;
    logic             in_ready;
    logic [NUM_W-1:0] out_data;
    logic             out_range;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_range, out_valid
    );

    modport slave (
        input  in_data, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_range, out_valid
    );
endinterface

// File: rtl/hyperbolic_cordic_unit.sv
// Iterative hyperbolic CORDIC: e^z by rotation, ln(x) by vectoring when CORDIC_LN_EN is defined.
// One micro-rotation per clock; shift indices 4, 13 and 40 are repeated for convergence.
module hyperbolic_cordic_unit #(
    parameter int NUM_W      = 16,
    parameter int FRAC_W     = 13,
    parameter int GUARD_W    = 3,
    parameter int ITERATIONS = NUM_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    hyperbolic_cordic_unit_if.slave     bus
);

    function automatic int num_repeats(input int iters);
        int n;
        n = 0;
        if (iters >= 4)  n++;
        if (iters >= 13) n++;
        if (iters >= 40) n++;
        return n;
    endfunction

    function automatic int shift_at(input int k);
        int n;
        int r;
        n = 0;
        r = ITERATIONS;
        for (int j = 1; j <= ITERATIONS; j++) begin
            if (n == k) r = j;
            n++;
            if (j == 4 || j == 13 || j == 40) begin
                if (n == k) r = j;
                n++;
            end
        end
        return r;
    endfunction

    localparam int XW    = NUM_W + GUARD_W + 1;
    localparam int ZW    = NUM_W + GUARD_W;
    localparam int RW    = XW + 1;
    localparam int QF    = FRAC_W + GUARD_W;
    localparam int STEPS = ITERATIONS + num_repeats(ITERATIONS);
    localparam int SW    = $clog2(STEPS);
    localparam int SHW   = $clog2(ITERATIONS + 1);

    localparam int InvKQ  = $rtoi(1.207497 * (2.0 ** QF) + 0.5);
    localparam int ExpLim = $rtoi(1.1182 * (2.0 ** FRAC_W));
    localparam int LnHi   = $rtoi(9.35 * (2.0 ** FRAC_W));
    localparam int LnLo   = $rtoi($ceil(0.107 * (2.0 ** FRAC_W)));

    localparam logic [SW-1:0]        LastStep = SW'(STEPS - 1);
    localparam logic signed [RW-1:0] RndHalf  = RW'(1 << (GUARD_W - 1));
    localparam logic [NUM_W-1:0]     SatMax   = {1'b0, {(NUM_W-1){1'b1}}};
    localparam logic [NUM_W-1:0]     SatMin   = {1'b1, {(NUM_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e                  r_state, w_state_d;
    logic [SW-1:0]           r_step;
    logic signed [XW-1:0]    r_x, r_y;
    logic signed [ZW-1:0]    r_z;
    logic                    r_range, r_neg;
    logic [NUM_W-1:0]        r_out_data;
    logic                    r_out_range, r_out_valid;

    logic                    w_accept, w_last, w_release;

    // Per-step shift index and atanh constant, built at elaboration.
    logic [SHW-1:0]          w_shift_tab [STEPS];
    logic signed [ZW-1:0]    w_atanh_tab [STEPS];

    for (genvar g = 0; g < STEPS; g++) begin : g_tab
        localparam int  Sh  = shift_at(g);
        localparam real AtR = $atanh(1.0 / (2.0 ** Sh)) * (2.0 ** QF);
        localparam int  AtQ = $rtoi(AtR + 0.5);
        assign w_shift_tab[g] = SHW'(Sh);
        assign w_atanh_tab[g] = ZW'(AtQ);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            StIdle: if (bus.in_valid) begin
                w_accept  = 1'b1;
                w_state_d = StIter;
            end
            StIter: if (r_step == LastStep) begin
                w_last    = 1'b1;
                w_state_d = StDone;
            end
            StDone: if (bus.out_ready) begin
                w_release = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    logic signed [31:0]      w_in_ext;
    logic signed [XW-1:0]    w_x_ld, w_y_ld;
    logic signed [ZW-1:0]    w_z_ld;
    logic                    w_range_ld, w_neg_ld;

    assign w_in_ext = {{(32-NUM_W){bus.in_data[NUM_W-1]}}, bus.in_data};

`ifdef CORDIC_LN_EN
    logic                    r_mode;
    logic signed [NUM_W:0]   w_in_p1, w_in_m1;
    assign w_in_p1 = {bus.in_data[NUM_W-1], bus.in_data} + (NUM_W+1)'(1 << FRAC_W);
    assign w_in_m1 = {bus.in_data[NUM_W-1], bus.in_data} - (NUM_W+1)'(1 << FRAC_W);
`endif

    always_comb begin
        w_x_ld     = XW'(InvKQ);
        w_y_ld     = '0;
        w_z_ld     = {bus.in_data, {GUARD_W{1'b0}}};
        w_range_ld = (w_in_ext > ExpLim) || (w_in_ext < -ExpLim);
        w_neg_ld   = 1'b0;
`ifdef CORDIC_LN_EN
        if (bus.in_mode) begin
            w_x_ld     = {w_in_p1, {GUARD_W{1'b0}}};
            w_y_ld     = {w_in_m1, {GUARD_W{1'b0}}};
            w_z_ld     = '0;
            w_range_ld = (w_in_ext <= 0) || (w_in_ext > LnHi) || (w_in_ext < LnLo);
            w_neg_ld   = (w_in_ext <= 0);
        end
`endif
    end

    logic [SHW-1:0]          w_sh;
    logic signed [ZW-1:0]    w_at;
    logic signed [XW-1:0]    w_xs, w_ys, w_x_n, w_y_n;
    logic signed [ZW-1:0]    w_z_n;
    logic                    w_dpos;

    assign w_sh = w_shift_tab[r_step];
    assign w_at = w_atanh_tab[r_step];
    assign w_xs = r_x >>> w_sh;
    assign w_ys = r_y >>> w_sh;

`ifdef CORDIC_LN_EN
    // Vectoring drives y toward zero; rotation drives z toward zero.
    assign w_dpos = r_mode ? r_y[XW-1] : ~r_z[ZW-1];
`else
    assign w_dpos = ~r_z[ZW-1];
`endif

    assign w_x_n = w_dpos ? (r_x + w_ys) : (r_x - w_ys);
    assign w_y_n = w_dpos ? (r_y + w_xs) : (r_y - w_xs);
    assign w_z_n = w_dpos ? (r_z - w_at) : (r_z + w_at);

    logic signed [RW-1:0]    w_res_exp, w_res, w_sum, w_rnd;
    logic                    w_fits;
    logic [NUM_W-1:0]        w_sat, w_out;

    assign w_res_exp = {w_x_n[XW-1], w_x_n} + {w_y_n[XW-1], w_y_n};
`ifdef CORDIC_LN_EN
    assign w_res = r_mode ? {w_z_n[ZW-1], w_z_n, 1'b0} : w_res_exp;
`else
    assign w_res = w_res_exp;
`endif
    assign w_sum  = w_res + RndHalf;
    assign w_rnd  = w_sum >>> GUARD_W;
    assign w_fits = (&w_rnd[RW-1:NUM_W-1]) | ~(|w_rnd[RW-1:NUM_W-1]);
    assign w_sat  = w_fits ? w_rnd[NUM_W-1:0] : (w_rnd[RW-1] ? SatMin : SatMax);
    assign w_out  = r_neg ? SatMin : w_sat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_step      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_range     <= 1'b0;
            r_neg       <= 1'b0;
            r_out_data  <= '0;
            r_out_range <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef CORDIC_LN_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_x     <= w_x_ld;
                r_y     <= w_y_ld;
                r_z     <= w_z_ld;
                r_step  <= '0;
                r_range <= w_range_ld;
                r_neg   <= w_neg_ld;
`ifdef CORDIC_LN_EN
                r_mode  <= bus.in_mode;
`endif
            end else if (r_state == StIter) begin
                r_x    <= w_x_n;
                r_y    <= w_y_n;
                r_z    <= w_z_n;
                r_step <= w_last ? '0 : r_step + SW'(1);
            end
            if (w_last) begin
                r_out_data  <= w_out;
                r_out_range <= r_range;
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_data  = r_out_data;
    assign bus.out_range = r_out_range;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_hyperbolic_cordic_unit.sv
// Directed and random checks of hyperbolic_cordic_unit at default parameters (Q3.13).
// Ln vectors are exercised only when CORDIC_LN_EN is defined.
module tb_hyperbolic_cordic_unit;

    localparam int Steps = 18;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    hyperbolic_cordic_unit_if #(.NUM_W(16)) bus ();

    hyperbolic_cordic_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        int diff;
        diff = obs - exp;
        n_checks++;
        assert (diff <= tol && diff >= -tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Waits for out_valid after an accept edge; lat counts edges, capped at 100.
    task automatic wait_result(output int res, output logic rng, output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = int'($signed(bus.out_data));
        rng = bus.out_range;
    endtask

    task automatic do_op(input logic [15:0] d, input logic m, output int res,
                         output logic rng, output int lat);
        @(negedge clk);
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(res, rng, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   res;
        int   lat;
        int   held;
        int   z;
        int   expv;
        int   saw;
        logic rng;

        rstn          = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_out_range", bus.out_range, 0);
        @(negedge clk);
        rstn = 1'b1;

        do_op(16'd0, 1'b0, res, rng, lat);
        check_eq("exp0_latency", lat, Steps);
        check_tol("exp0_data", res, 8192, 2);
        check_eq("exp0_range", rng, 0);

        do_op(16'd8192, 1'b0, res, rng, lat);
        check_tol("exp1_data", res, 22268, 2);
        check_eq("exp1_range", rng, 0);

        do_op(-16'sd8192, 1'b0, res, rng, lat);
        check_tol("expm1_data", res, 3014, 2);

        do_op(16'd12288, 1'b0, res, rng, lat);
        check_eq("exp15_range", rng, 1);

`ifdef CORDIC_LN_EN
        do_op(16'd16384, 1'b1, res, rng, lat);
        check_eq("ln2_latency", lat, Steps);
        check_tol("ln2_data", res, 5678, 3);
        check_eq("ln2_range", rng, 0);

        do_op(16'd0, 1'b1, res, rng, lat);
        check_eq("ln0_range", rng, 1);
        check_eq("ln0_data", res, -32768);
`endif

        // Output stall: result held, input side closed, stray in_valid ignored.
        @(negedge clk);
        bus.in_data   = 16'd8192;
        bus.in_mode   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(res, rng, lat);
        check_eq("hold_latency", lat, Steps);
        check_tol("hold_data", res, 22268, 2);
        held = res;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = (k == 3);
            bus.in_data  = 16'h1000;
            @(posedge clk);
            #1;
            check_eq("hold_stable", $signed(bus.out_data), held);
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_valid", bus.out_valid, 0);
        check_eq("release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_data  = -16'sd8192;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_eq("next_accepted", bus.in_ready, 0);
        wait_result(res, rng, lat);
        check_eq("next_latency", lat, Steps);
        check_tol("next_data", res, 3014, 2);
        @(posedge clk);
        #1;

        // Reset in the middle of the iteration sequence.
        @(negedge clk);
        bus.in_data  = 16'd8192;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_eq("midrst_in_ready", bus.in_ready, 1);
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_out_data", bus.out_data, 0);
        check_eq("midrst_out_range", bus.out_range, 0);
        @(negedge clk);
        rstn = 1'b1;
        saw = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) saw++;
        end
        check_eq("midrst_no_result", saw, 0);
        do_op(16'd0, 1'b0, res, rng, lat);
        check_tol("postrst_exp0", res, 8192, 2);

        // Back-to-back random rotations against a real-valued model.
        for (int v = 0; v < 1000; v++) begin
            z    = int'($urandom_range(18022)) - 9011;
            expv = $rtoi($exp(real'(z) / 8192.0) * 8192.0 + 0.5);
            do_op(16'(z), 1'b0, res, rng, lat);
            check_eq("rand_latency", lat, Steps);
            check_tol("rand_exp", res, expv, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbolic_cordic_unit.md
# hyperbolic_cordic_unit

Parametrised iterative hyperbolic CORDIC engine. Computes e^z (rotation mode) and, when compiled in, ln(x) (vectoring mode) on signed fixed-point operands. It performs one micro-rotation per clock and uses valid/ready handshakes on both sides. It is the generalised successor of the fixed 16-bit exp-only unit and sits between the diode-model sample pipeline and the shunt-current solver.

## Interface
- NUM_W, 16, operand/result width, two's complement
- FRAC_W, 13, fractional bits; number format Q(NUM_W-FRAC_W).FRAC_W
- GUARD_W, 3, extra LSBs carried internally on x, y, z datapaths
- ITERATIONS, NUM_W, highest shift index i (i = 1..ITERATIONS)

- clk  in  1  clock
- rstn  in  1  reset; one clock; asynchronous assert, active-low
- in_data  in  NUM_W  z (exp) or x (ln)
- in_mode  in  1  0 = exp, 1 = ln; ignored without CORDIC_LN_EN
- in_valid  in  1  input strobe
- in_ready  out  1  high only in IDLE
- out_data  out  NUM_W  result, held until output handshake
- out_range  out  1  input outside convergence range
- out_valid  out  1  result available
- out_ready  in  1  downstream accept

## Operation
- States: IDLE, ITER, DONE. Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_range=0, step counter=0.
- Step sequence: i = 1..ITERATIONS, with i=4, 13, 40 each executed twice when present. STEPS = ITERATIONS + number of repeats; for NUM_W=16 this is 18.
- Atanh table: round(atanh(2^-i)·2^(FRAC_W+GUARD_W)), generated at elaboration with $atanh. No hand-written constants.
- Exp load: x=1/K_h (1.207497·2^(FRAC_W+GUARD_W), rounded), y=0, z=in_data<<GUARD_W.
- Exp step:
  - d = +1 if z ≥ 0, else -1.
  - x' = x + d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atanh_i.
  - Result = x+y.
- Ln load: x=in_data+1.0, y=in_data−1.0, z=0, all widened by GUARD_W.
- Ln step:
  - d = −1 if y ≥ 0, else +1.
  - Same x/y/z update as exp.
  - Result = 2z.
- Output: result rounded half-up by dropping GUARD_W bits, then saturated to the NUM_W signed range.
- out_range, latched at accept:
  - exp: |z| > 1.1182.
  - ln: x ≤ 0 or x > 9.35 or x < 0.107.
  - The computation still runs. For ln with x ≤ 0, out_data is forced to the most negative value.
- Internal width: NUM_W+GUARD_W+1 on x/y (headroom), NUM_W+GUARD_W on z.

## Timing
- Accept on the edge where in_valid & in_ready. That edge loads x/y/z, sets state=ITER and drops in_ready.
- Each following edge executes one step. On the STEPS-th step edge:
  - out_data, out_range and out_valid are registered;
  - state=DONE.
- Latency: out_valid is high STEPS cycles after the accept edge (18 at defaults).
- DONE holds out_data/out_valid stable indefinitely while out_ready=0.
- Output handshake edge (out_valid & out_ready): out_valid=0, state=IDLE. in_ready rises on that same edge, so a new input can be accepted on the next edge. Throughput is one result per STEPS+2 cycles.
- in_valid during ITER/DONE is ignored; no input is captured.
- in_data/in_mode are sampled only on the accept edge.
- rstn low at any time, including mid-ITER: immediate return to reset values. The partial result is discarded and no out_valid is produced.

## Configuration
- CORDIC_LN_EN defined: vectoring/ln path, in_mode decode and ln range check are built.
- CORDIC_LN_EN undefined:
  - exp-only; in_mode is ignored and treated as 0;
  - no ln load/direction logic is synthesised;
  - timing is identical.

## Test plan
All values are at defaults (Q3.13, 1.0 = 8192).
- Exp, in_data=0 -> out_data=8192 ±2, out_range=0; out_valid exactly 18 cycles after accept.
- Exp, in_data=8192 (1.0) -> 22268 ±2. Exp, in_data=−8192 -> 3014 ±2. Exp, in_data=12288 (1.5) -> out_range=1.
- Ln (CORDIC_LN_EN), in_data=16384 (2.0) -> 5678 ±3. in_data=0 -> out_range=1, out_data=−32768.
- Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a second in_valid is ignored. Then out_ready=1 -> next input is accepted the following edge with the correct result.
- Deassert rstn at step 7 -> all outputs take reset values immediately. A post-reset exp(0) returns 8192 ±2.
- Back-to-back random z in [−1.1, 1.1], 1000 vectors -> error ≤ 3 LSB against a real-valued model, and no lost or duplicated results.
